multicycle_issue_ctrl: RTL



---
 rtl/multicycle_issue_ctrl_pkg.sv | 19 +
 rtl/mc_timeout_counter.sv | 29 ++
 rtl/multicycle_issue_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_issue_ctrl_pkg.sv
// Shared types and helpers for the multi-cycle issue/stall controller.
package multicycle_issue_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CTRL_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } mcState_t;

  // LSB of unit idx's result inside the packed result bus.
  function automatic int unsigned sliceLsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mc_timeout_counter.sv
// Wait-cycle counter for the issue controller; flags the cycle whose increment reaches TIMEOUT-1.
module mc_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iClr,
  input  logic iEn,
  output logic oTerm
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      count <= '0;
    end else if (iClr) begin
      count <= '0;
    end else if (iEn) begin
      count <= count + 1'b1;
    end
  end

  // Terminal is raised one cycle early so the FSM leaves WAIT as the count lands on TIMEOUT-1.
  assign oTerm = iEn && (count == CNT_W'(TIMEOUT - 2));

endmodule

// File: rtl/multicycle_issue_ctrl.sv
// Issue/stall controller for multi-cycle execution units: launches one op, waits for done, writes back once.
module multicycle_issue_ctrl
  import multicycle_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned CTRL_W    = DEF_CTRL_W,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned SEL_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic                        iValid,
  input  logic [SEL_W-1:0]            iUnitSel,
  input  logic [DATA_W-1:0]           iOpA,
  input  logic [DATA_W-1:0]           iOpB,
  input  logic [CTRL_W-1:0]           iCtrl,
  input  logic [4:0]                  iRd,
  input  logic                        iDestFP,
  output logic [NUM_UNITS-1:0]        oStart,
  output logic [DATA_W-1:0]           oOpA,
  output logic [DATA_W-1:0]           oOpB,
  output logic [CTRL_W-1:0]           oCtrl,
  input  logic [NUM_UNITS-1:0]        iDone,
  input  logic [NUM_UNITS*DATA_W-1:0] iResult,
  output logic                        oStall,
  output logic                        oBusy,
  output logic                        oWbEn,
  output logic                        oWbFP,
  output logic [4:0]                  oWbRd,
  output logic [DATA_W-1:0]           oWbData,
  output logic                        oTimeout,
  output logic                        oIllegal
);

  mcState_t            state;
  mcState_t            stateNext;
  logic [DATA_W-1:0]   opA;
  logic [DATA_W-1:0]   opB;
  logic [CTRL_W-1:0]   ctrlReg;
  logic [4:0]          rdReg;
  logic                fpReg;
  logic [SEL_W-1:0]    selReg;
  logic [DATA_W-1:0]   wbData;
  logic                errTimeout;
  logic                errIllegal;

  logic                selLegal;
  logic                doneSel;
  logic [DATA_W-1:0]   resSel;
  logic                term;
  logic                inWb;
  logic                wbWrite;
  logic                wbShow;

  generate
    if (NUM_UNITS >= (1 << SEL_W)) begin : gAllLegal
      assign selLegal = 1'b1;
    end else begin : gRangeCheck
      assign selLegal = (iUnitSel < SEL_W'(NUM_UNITS));
    end
  endgenerate

  mc_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) uTimeout (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iClr  (state == ISSUE),
    .iEn   (state == WAIT),
    .oTerm (term)
  );

  // Selected unit's done/result; other units' strobes never reach the FSM.
  always_comb begin
    doneSel = 1'b0;
    resSel  = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      if (selReg == SEL_W'(k)) begin
        doneSel = iDone[k];
        resSel  = iResult[sliceLsb(k, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iValid) stateNext = selLegal ? ISSUE : WB;
      ISSUE:   stateNext = WAIT;
      WAIT:    if (doneSel || term) stateNext = WB;
      WB:      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      opA        <= '0;
      opB        <= '0;
      ctrlReg    <= '0;
      rdReg      <= '0;
      fpReg      <= 1'b0;
      selReg     <= '0;
      wbData     <= '0;
      errTimeout <= 1'b0;
      errIllegal <= 1'b0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (iValid) begin
            opA        <= iOpA;
            opB        <= iOpB;
            ctrlReg    <= iCtrl;
            rdReg      <= iRd;
            fpReg      <= iDestFP;
            selReg     <= iUnitSel;
            wbData     <= '0;
            errTimeout <= 1'b0;
            errIllegal <= !selLegal;
          end
        end
        WAIT: begin
          // Done outranks a coincident timeout.
          if (doneSel) begin
            wbData <= resSel;
          end else if (term) begin
            wbData     <= '0;
            errTimeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oStart = '0;
    if (state == ISSUE) begin
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        oStart[k] = (selReg == SEL_W'(k));
      end
    end
  end

  // Stall is gated by reset so every output reads 0 while iRST_N is low.
  assign oStall = (state == IDLE) ? (iRST_N & iValid) : (state != WB);
  assign oBusy  = (state != IDLE);

  assign inWb    = (state == WB);
  assign wbWrite = inWb && (fpReg || (rdReg != 5'd0));
  assign wbShow  = wbWrite || (inWb && (errTimeout || errIllegal));

  assign oWbEn    = wbWrite;
  assign oWbFP    = wbShow && fpReg;
  assign oWbRd    = wbShow ? rdReg : '0;
  assign oWbData  = wbShow ? wbData : '0;
  assign oTimeout = inWb && errTimeout;
  assign oIllegal = inWb && errIllegal;

  assign oOpA  = opA;
  assign oOpB  = opB;
  assign oCtrl = ctrlReg;

endmodule
